stage_responder: RTL and testbench

STAGE_RESPONDER -- requirements
Module: stage_responder

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/saturating_counter.sv | 22 ++
 rtl/stage_responder.sv | 123 ++++++++++++
 tb/tb_stage_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline stage handshake: FSM states and sticky fault codes.
package pipeline_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        COMMIT = 3'd3,
        FAULT  = 3'd4
    } stageState_t;

    typedef enum logic [1:0] {
        FAULT_NONE       = 2'b00,
        FAULT_TIMEOUT    = 2'b01,
        FAULT_START_BUSY = 2'b10
    } faultCode_t;

endpackage

// File: rtl/saturating_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones instead of wrapping.
module saturating_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clockIn,
    input  logic             resetIn,
    input  logic             clearIn,
    input  logic             enableIn,
    output logic [WIDTH-1:0] countOut
);

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            countOut <= '0;
        end else if (clearIn) begin
            countOut <= '0;
        end else if (enableIn && (countOut != '1)) begin
            countOut <= countOut + 1'b1;
        end
    end

endmodule

// File: rtl/stage_responder.sv
// Per-stage launch/wait/commit sequencer with timeout and start-while-busy fault detection.
// Define STAGE_PERF_COUNTER_EN to build the busy-cycle performance counter.
module stage_responder
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int COUNTER_WIDTH  = 16
) (
    input  logic                     clockIn,
    input  logic                     resetIn,
    input  logic                     startIn,
    input  logic                     clearIn,
    input  logic                     jumpIn,
    input  logic                     operationDoneIn,
    output logic                     operationStartOut,
    output logic                     latchEnableOut,
    output logic                     readyOut,
    output logic [1:0]               faultOut,
    output logic [COUNTER_WIDTH-1:0] busyCyclesOut
);

    stageState_t              state;
    stageState_t              nextState;
    faultCode_t               faultReg;
    faultCode_t               nextFault;
    logic [COUNTER_WIDTH-1:0] waitCount;
    logic                     timeoutHit;

    // Held at zero outside WAIT so every operation starts its wait count afresh.
    saturating_counter #(.WIDTH(COUNTER_WIDTH)) waitCounter (
        .clockIn  (clockIn),
        .resetIn  (resetIn),
        .clearIn  (clearIn || (state != WAIT)),
        .enableIn (state == WAIT),
        .countOut (waitCount)
    );

    assign timeoutHit = (TIMEOUT_CYCLES != 0) && (state == WAIT) &&
                        (64'(waitCount) == (64'(TIMEOUT_CYCLES) - 64'd1));

`ifdef STAGE_PERF_COUNTER_EN
    saturating_counter #(.WIDTH(COUNTER_WIDTH)) busyCounter (
        .clockIn  (clockIn),
        .resetIn  (resetIn),
        .clearIn  (clearIn),
        .enableIn (state != IDLE),
        .countOut (busyCyclesOut)
    );
`else
    assign busyCyclesOut = '0;
`endif

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            state    <= IDLE;
            faultReg <= FAULT_NONE;
        end else begin
            state    <= nextState;
            faultReg <= nextFault;
        end
    end

    // Priority: clear, then jump flush, then timeout, then start-while-busy, then done.
    always_comb begin
        nextState = state;
        nextFault = faultReg;
        if (clearIn) begin
            nextState = IDLE;
            nextFault = FAULT_NONE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (startIn) nextState = LAUNCH;
                end
                LAUNCH: begin
                    if (jumpIn) begin
                        nextState = IDLE;
                    end else if (startIn) begin
                        nextState = FAULT;
                        nextFault = FAULT_START_BUSY;
                    end else begin
                        nextState = WAIT;
                    end
                end
                WAIT: begin
                    if (jumpIn) begin
                        nextState = IDLE;
                    end else if (timeoutHit && !operationDoneIn) begin
                        nextState = FAULT;
                        nextFault = FAULT_TIMEOUT;
                    end else if (startIn) begin
                        nextState = FAULT;
                        nextFault = FAULT_START_BUSY;
                    end else if (operationDoneIn) begin
                        nextState = COMMIT;
                    end
                end
                COMMIT: begin
                    if (startIn) begin
                        nextState = FAULT;
                        nextFault = FAULT_START_BUSY;
                    end else begin
                        nextState = IDLE;
                    end
                end
                FAULT: begin
                    nextState = FAULT;
                end
                default: begin
                    nextState = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        readyOut          = (state == IDLE);
        operationStartOut = (state == LAUNCH);
        latchEnableOut    = (state == COMMIT);
        faultOut          = faultReg;
    end

endmodule

// File: tb/tb_stage_responder.sv
// Directed vector bench for stage_responder built with TIMEOUT_CYCLES=4, COUNTER_WIDTH=3.
// Busy-counter expectations follow STAGE_PERF_COUNTER_EN as defined for the build.
module tb_stage_responder;

    logic       clockIn;
    logic       resetIn;
    logic       startIn;
    logic       clearIn;
    logic       jumpIn;
    logic       operationDoneIn;
    logic       operationStartOut;
    logic       latchEnableOut;
    logic       readyOut;
    logic [1:0] faultOut;
    logic [2:0] busyCyclesOut;

    int passCount  = 0;
    int checkCount = 0;

    typedef struct {
        logic       start;
        logic       clear;
        logic       jump;
        logic       done;
        logic       expStart;
        logic       expLatch;
        logic       expReady;
        logic [1:0] expFault;
        int         expBusy;
    } vector_t;

    vector_t vectors[$];

    stage_responder #(.TIMEOUT_CYCLES(4), .COUNTER_WIDTH(3)) dut (
        .clockIn           (clockIn),
        .resetIn           (resetIn),
        .startIn           (startIn),
        .clearIn           (clearIn),
        .jumpIn            (jumpIn),
        .operationDoneIn   (operationDoneIn),
        .operationStartOut (operationStartOut),
        .latchEnableOut    (latchEnableOut),
        .readyOut          (readyOut),
        .faultOut          (faultOut),
        .busyCyclesOut     (busyCyclesOut)
    );

    initial clockIn = 1'b0;
    always #5 clockIn = ~clockIn;

    function automatic vector_t vec(input logic s, input logic c, input logic j, input logic d,
                                    input logic oS, input logic l, input logic r,
                                    input logic [1:0] f, input int b);
        vector_t v;
        v.start = s; v.clear = c; v.jump = j; v.done = d;
        v.expStart = oS; v.expLatch = l; v.expReady = r; v.expFault = f; v.expBusy = b;
        return v;
    endfunction

    // Inputs change at the falling edge; outputs are sampled 1ns after the next rising edge.
    task automatic applyStimulus(input logic s, input logic c, input logic j, input logic d);
        @(negedge clockIn);
        startIn = s; clearIn = c; jumpIn = j; operationDoneIn = d;
        @(posedge clockIn);
        #1;
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic checkOutput(input string tag, input logic oS, input logic l, input logic r,
                               input logic [1:0] f);
        checkValue({tag, " operationStartOut"}, int'(operationStartOut), int'(oS));
        checkValue({tag, " latchEnableOut"}, int'(latchEnableOut), int'(l));
        checkValue({tag, " readyOut"}, int'(readyOut), int'(r));
        checkValue({tag, " faultOut"}, int'(faultOut), int'(f));
    endtask

    initial begin
        int expBusy;

        // start, clear, jump, done | launch, latch, ready, fault, busy
        vectors.push_back(vec(1,0,0,0, 1,0,0,2'd0, 0));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 1));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 2));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 3));
        vectors.push_back(vec(0,0,0,1, 0,1,0,2'd0, 4));
        vectors.push_back(vec(0,0,0,0, 0,0,1,2'd0, 5));
        vectors.push_back(vec(0,0,0,1, 0,0,1,2'd0, 5));
        vectors.push_back(vec(1,0,1,0, 1,0,0,2'd0, 5));
        vectors.push_back(vec(0,0,1,0, 0,0,1,2'd0, 6));
        vectors.push_back(vec(1,0,0,0, 1,0,0,2'd0, 6));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 7));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 7));
        vectors.push_back(vec(0,0,1,0, 0,0,1,2'd0, 7));
        vectors.push_back(vec(0,0,0,1, 0,0,1,2'd0, 7));
        vectors.push_back(vec(1,0,0,0, 1,0,0,2'd0, 7));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 7));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 7));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 7));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 7));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd1, 7));
        vectors.push_back(vec(0,0,0,1, 0,0,0,2'd1, 7));
        vectors.push_back(vec(1,0,0,0, 0,0,0,2'd1, 7));
        vectors.push_back(vec(0,0,1,0, 0,0,0,2'd1, 7));
        vectors.push_back(vec(0,1,0,0, 0,0,1,2'd0, 0));
        vectors.push_back(vec(1,0,0,0, 1,0,0,2'd0, 0));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 1));
        vectors.push_back(vec(1,0,0,0, 0,0,0,2'd2, 2));
        vectors.push_back(vec(0,1,0,0, 0,0,1,2'd0, 0));
        vectors.push_back(vec(1,0,0,0, 1,0,0,2'd0, 0));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 1));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 2));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 3));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 4));
        vectors.push_back(vec(0,0,0,1, 0,1,0,2'd0, 5));
        vectors.push_back(vec(0,0,0,0, 0,0,1,2'd0, 6));
        vectors.push_back(vec(1,0,0,0, 1,0,0,2'd0, 6));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 7));
        vectors.push_back(vec(0,0,0,1, 0,1,0,2'd0, 7));
        vectors.push_back(vec(1,0,0,0, 0,0,0,2'd2, 7));
        vectors.push_back(vec(0,1,0,0, 0,0,1,2'd0, 0));
        vectors.push_back(vec(1,0,0,0, 1,0,0,2'd0, 0));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 1));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 2));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 3));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 4));
        vectors.push_back(vec(1,0,0,0, 0,0,0,2'd1, 5));
        vectors.push_back(vec(0,1,0,0, 0,0,1,2'd0, 0));
        vectors.push_back(vec(1,0,0,0, 1,0,0,2'd0, 0));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 1));
        vectors.push_back(vec(0,1,0,0, 0,0,1,2'd0, 0));
        vectors.push_back(vec(1,0,0,0, 1,0,0,2'd0, 0));
        vectors.push_back(vec(0,0,0,0, 0,0,0,2'd0, 1));
        vectors.push_back(vec(0,0,0,1, 0,1,0,2'd0, 2));
        vectors.push_back(vec(0,0,1,0, 0,0,1,2'd0, 3));

        resetIn = 1'b0;
        startIn = 1'b0; clearIn = 1'b0; jumpIn = 1'b0; operationDoneIn = 1'b0;
        #1;
        checkOutput("reset", 1'b0, 1'b0, 1'b1, 2'd0);
        checkValue("reset busyCyclesOut", int'(busyCyclesOut), 0);
        @(negedge clockIn);
        resetIn = 1'b1;

        foreach (vectors[i]) begin
            applyStimulus(vectors[i].start, vectors[i].clear, vectors[i].jump, vectors[i].done);
            checkOutput($sformatf("vec%0d", i), vectors[i].expStart, vectors[i].expLatch,
                        vectors[i].expReady, vectors[i].expFault);
`ifdef STAGE_PERF_COUNTER_EN
            expBusy = vectors[i].expBusy;
`else
            expBusy = 0;
`endif
            checkValue($sformatf("vec%0d busyCyclesOut", i), int'(busyCyclesOut), expBusy);
        end

        // Reference timing: start in cycle 2, done in cycle 5.
        @(negedge clockIn);
        resetIn = 1'b0;
        @(negedge clockIn);
        resetIn = 1'b1;
        applyStimulus(0, 0, 0, 0);
        checkOutput("ref cycle2", 1'b0, 1'b0, 1'b1, 2'd0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("ref cycle3 launch", 1'b1, 1'b0, 1'b0, 2'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("ref cycle4", 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("ref cycle5", 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("ref cycle6 latch", 1'b0, 1'b1, 1'b0, 2'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("ref cycle7 ready", 1'b0, 1'b0, 1'b1, 2'd0);

        // Asynchronous reset in the middle of a WAIT cycle, then a stale done.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        #2;
        resetIn = 1'b0;
        #1;
        checkOutput("async reset in WAIT", 1'b0, 1'b0, 1'b1, 2'd0);
        checkValue("async reset busyCyclesOut", int'(busyCyclesOut), 0);
        @(negedge clockIn);
        resetIn = 1'b1;
        applyStimulus(0, 0, 0, 1);
        checkOutput("stale done after reset", 1'b0, 1'b0, 1'b1, 2'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("idle after stale done", 1'b0, 1'b0, 1'b1, 2'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
